ram512_stream_port: RTL and testbench
=====================================

# ram512_stream_port

Sequencer directly upstream of the 512-word RAM. It turns a start command (mode, base address, word count) into a burst of RAM accesses. In write mode it takes words from a valid/ready input stream and drives the RAM's `load`/`address`/`in` pins. In read mode it walks the RAM address and presents `out` on a valid/ready output stream. It lets a producer fill, or a consumer drain, a RAM512 region without computing addresses itself.

## Interface

- `ADDR_W`, 9: RAM address width; 512 words.
- `DATA_W`, 16: word width.

- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: command strobe; sampled only in IDLE.
- `mode` in 1: 0 = write burst (stream → RAM), 1 = read burst (RAM → stream).
- `base` in ADDR_W: first RAM address of the burst.
- `count` in ADDR_W+1: words in burst, 0..512.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a burst completes.
- `s_valid` in 1, `s_data` in DATA_W, `s_ready` out 1: write-data input stream.
- `m_valid` out 1, `m_data` out DATA_W, `m_ready` in 1: read-data output stream.
- `ram_load` out 1, `ram_address` out ADDR_W, `ram_in` out DATA_W: drive RAM512 `load`/`address`/`in`.
- `ram_out` in DATA_W: from RAM512 `out`; combinational in the current address.

## Operation

- States: IDLE, WRITE, READ, DONE.
- IDLE, `start`=1: latch `base` into `ptr`, `count` into `remaining`, and `mode`.
  - `count`=0: go to DONE.
  - Otherwise go to WRITE (`mode`=0) or READ (`mode`=1).
- `start` in any state other than IDLE is ignored. `base`, `count` and `mode` matter only in the start cycle.
- WRITE:
  - `s_ready`=1 and `ram_address`=`ptr`.
  - `ram_in` = `s_data`.
  - `ram_load` = `s_valid`, so the RAM writes at the same edge the beat is accepted.
  - Each beat (`s_valid`&&`s_ready`): `ptr` ← `ptr`+1 mod 512, `remaining` ← `remaining`−1.
  - Beat with `remaining`=1: go to DONE.
- READ:
  - `ram_address`=`ptr`, `ram_load`=0.
  - `m_valid`=1, `m_data`=`ram_out`.
  - Each beat (`m_valid`&&`m_ready`): `ptr` and `remaining` update as in WRITE.
  - Beat with `remaining`=1: go to DONE.
  - While `m_ready`=0, `ptr` holds, so `m_data` stays stable.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Address wrap: a burst crossing 511 continues at 0. `count`=512 touches every word exactly once.
- Outside a burst:
  - In IDLE and DONE: `ram_load`=0, `s_ready`=0, `m_valid`=0, `ram_in`=0, `m_data`=`ram_out`.
  - In IDLE, DONE and WRITE: `m_valid`=0.
  - In IDLE, DONE and READ: `s_ready`=0.
  - In IDLE and DONE, `ram_address` holds the last `ptr`.
- Reset:
  - State→IDLE, `ptr`=0, `remaining`=0.
  - Reset values of outputs: `busy`=0, `done`=0, `s_ready`=0, `m_valid`=0, `ram_load`=0, `ram_address`=0.
  - While `reset`=1: `ram_load`, `s_ready` and `m_valid` are forced 0 combinationally, regardless of state.
  - Reset mid-burst aborts the burst with no `done` pulse. Words already written stay in RAM; reset never clears RAM.

## Timing

- `start` seen at edge N: `busy`=1 from cycle N+1. The first beat can be accepted in cycle N+1.
- Throughput: one word per cycle with no stalls. A burst of k words with no stalls ends with `done` in cycle N+1+k and IDLE in cycle N+2+k.
- `count`=0: `done` in cycle N+1, IDLE in cycle N+2.
- A new `start` is accepted in the first IDLE cycle; there is no overlap with DONE.
- Write path:
  - The RAM captures `ram_in` at the edge ending the beat cycle.
  - A read burst started afterwards sees the written data with no extra delay.
- Read path:
  - `m_data` is combinational from `ram_out`; there is no pipeline register.
  - A word is valid in the same cycle its address is driven.

## Test plan

- Write burst: `base`=10, `count`=4, data 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles → `ram_load` high 4 cycles at addresses 10..13, `done` pulse 1 cycle later. Then read burst `base`=10, `count`=4 with `m_ready`=1 → `m_data` sequence 0x1111..0x4444.
- Wrap: write `base`=510, `count`=4, data 0xA0..0xA3 → writes at 510, 511, 0, 1. Read back `base`=510 returns the same sequence.
- Backpressure:
  - Read burst of 3 with `m_ready` toggling 1,0,0,1,1 → `m_data` holds while stalled, exactly 3 beats delivered, `done` after the 5th cycle.
  - Write burst of 3 with `s_valid` gaps → `ram_load`=0 in gap cycles, and `ptr` does not advance during gaps.
- `count`=0 → `busy` for 1 cycle, `done` pulse, no `ram_load`, no `m_valid`.
- `start` while busy (mid 4-word write) → ignored, burst completes unchanged. `count`=512 fill of 0xFFFF → all 512 addresses read back 0xFFFF.
- Reset after 2 of 4 write beats → `ram_load`, `busy` and `s_ready` are 0 from the reset cycle onward, no `done` pulse. The 2 written words persist, and the next `start` works normally.

Source files
------------

// File: rtl/ram512_stream_port.sv
// Burst sequencer in front of the 512-word RAM: a start command becomes a run of
// RAM writes fed by a valid/ready input stream, or RAM reads drained to an output stream.
module ram512_stream_port #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              ram_load,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_in,
   input  logic [DATA_W-1:0] ram_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   remaining;
   logic              beat;

   // The burst direction lives in the state itself, so no separate mode register is kept.
   assign beat = ((state == WRITE) && s_valid) || ((state == READ) && m_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ptr       <= base;
                  remaining <= count;
                  if (count == '0)
                     state <= DONE;
                  else if (mode)
                     state <= READ;
                  else
                     state <= WRITE;
               end
            end
            WRITE, READ: begin
               if (beat) begin
                  ptr       <= ptr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == {{ADDR_W{1'b0}}, 1'b1})
                     state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Handshake and status outputs are decoded from the state register and held low during reset.
   assign busy     = !reset && (state != IDLE);
   assign done     = !reset && (state == DONE);
   assign s_ready  = !reset && (state == WRITE);
   assign m_valid  = !reset && (state == READ);
   assign ram_load = !reset && (state == WRITE) && s_valid;

   assign ram_address = ptr;
   assign ram_in      = (state == WRITE) ? s_data : '0;
   assign m_data      = ram_out;

endmodule

// File: tb/tb_ram512_stream_port.sv
// Bench for ram512_stream_port: a RAM512 model, a transaction-level reference model
// compared every cycle, and directed bursts with literal expectations.
module tb_ram512_stream_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mode;
   logic [8:0]  base;
   logic [9:0]  count;
   logic        busy;
   logic        done;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        m_valid;
   logic [15:0] m_data;
   logic        m_ready;
   logic        ram_load;
   logic [8:0]  ram_address;
   logic [15:0] ram_in;
   logic [15:0] ram_out;

   int checks   = 0;
   int failures = 0;
   bit checking = 1'b0;
   int doneCount = 0;
   logic [15:0] wdata [$];
   logic [15:0] readLog [$];

   always #5 clk = ~clk;

   ram512_stream_port #(.ADDR_W(9), .DATA_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base), .count(count),
      .busy(busy), .done(done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .ram_load(ram_load),
      .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
   );

   // RAM512 stand-in: synchronous write, combinational read of the current address.
   logic [15:0] ramMem [512];
   initial for (int i = 0; i < 512; i++) ramMem[i] = 16'h0;
   always @(posedge clk) if (ram_load) ramMem[ram_address] <= ram_in;
   assign ram_out = ramMem[ram_address];

   // Reference model: tracks a burst as base + beats accepted, plus a golden copy of memory.
   logic [15:0] gold [512];
   int phase = 0;
   bit isRead = 1'b0;
   int mBase = 0, mCount = 0, acc = 0;
   initial for (int i = 0; i < 512; i++) gold[i] = 16'h0;

   always @(posedge clk) begin
      if (reset) begin
         phase = 0; mBase = 0; acc = 0; mCount = 0;
      end else begin
         case (phase)
            0: if (start) begin
                  mBase = int'(base); mCount = int'(count); acc = 0; isRead = mode;
                  phase = (count == 10'd0) ? 2 : 1;
               end
            1: if (isRead ? m_ready : s_valid) begin
                  if (!isRead) gold[(mBase + acc) % 512] = s_data;
                  acc++;
                  if (acc == mCount) phase = 2;
               end
            default: phase = 0;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         int  expAddr;
         bit  inBurst;
         expAddr = (mBase + acc) % 512;
         inBurst = (phase == 1);
         checkOutput("busy",     busy,     !reset && phase != 0);
         checkOutput("done",     done,     !reset && phase == 2);
         checkOutput("s_ready",  s_ready,  !reset && inBurst && !isRead);
         checkOutput("m_valid",  m_valid,  !reset && inBurst && isRead);
         checkOutput("ram_load", ram_load, !reset && inBurst && !isRead && s_valid);
         checkOutput("ram_addr", ram_address, expAddr);
         checkOutput("ram_in",   ram_in,   (inBurst && !isRead) ? s_data : 16'h0);
         checkOutput("m_data",   m_data,   gold[expAddr]);
         if (done) doneCount++;
         if (m_valid && m_ready) readLog.push_back(m_data);
      end
   end

   // Issues one burst; mask bit c-1 gives valid/ready in cycle c after start (1 beyond bit 31).
   task automatic applyStimulus(input bit md, input int b, input int cnt, input logic [31:0] mask,
                                input int startAt, output int doneCycle);
      int beatIdx;
      bit v;
      doneCycle = 0;
      beatIdx = 0;
      readLog.delete();
      @(posedge clk); #1;
      start = 1'b1; mode = md; base = 9'(b); count = 10'(cnt);
      @(posedge clk); #1;
      start = 1'b0; mode = 1'b0; base = 9'd0; count = 10'd0;
      for (int c = 1; c <= 700; c++) begin
         v = (c > 32) ? 1'b1 : mask[c-1];
         if (c == startAt) begin
            start = 1'b1; mode = 1'b1; base = 9'd0; count = 10'd1;
         end else begin
            start = 1'b0;
         end
         s_valid = v && !md;
         m_ready = v && md;
         s_data  = (v && !md && beatIdx < wdata.size()) ? wdata[beatIdx] : 16'hDEAD;
         if (v && !md) beatIdx++;
         @(negedge clk);
         if (done) begin
            doneCycle = c;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 16'h0; mode = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int dc;
      int ffCount;
      int doneBefore;
      reset = 1'b1; start = 1'b0; mode = 1'b0; base = '0; count = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      @(posedge clk);
      checking = 1'b1;
      @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_addr", ram_address, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      $display("[TB] basic write/read");
      wdata = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      applyStimulus(1'b0, 10, 4, 32'hFFFF_FFFF, 0, dc);
      checkOutput("wr_done_cycle", dc, 5);
      applyStimulus(1'b1, 10, 4, 32'hFFFF_FFFF, 0, dc);
      checkOutput("rd_done_cycle", dc, 5);
      checkOutput("rd_len", readLog.size(), 4);
      if (readLog.size() == 4) begin
         checkOutput("rd0", readLog[0], 16'h1111);
         checkOutput("rd1", readLog[1], 16'h2222);
         checkOutput("rd2", readLog[2], 16'h3333);
         checkOutput("rd3", readLog[3], 16'h4444);
      end

      $display("[TB] address wrap");
      wdata = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
      applyStimulus(1'b0, 510, 4, 32'hFFFF_FFFF, 0, dc);
      checkOutput("wrap_wr_done", dc, 5);
      applyStimulus(1'b1, 510, 4, 32'hFFFF_FFFF, 0, dc);
      checkOutput("wrap_rd_done", dc, 5);
      checkOutput("wrap_len", readLog.size(), 4);
      if (readLog.size() == 4) begin
         checkOutput("wrap0", readLog[0], 16'h00A0);
         checkOutput("wrap3", readLog[3], 16'h00A3);
      end
      checkOutput("wrap_mem0", ramMem[0], 16'h00A2);
      checkOutput("wrap_mem511", ramMem[511], 16'h00A1);

      $display("[TB] read backpressure");
      applyStimulus(1'b1, 10, 3, 32'b11001, 0, dc);
      checkOutput("bp_done_cycle", dc, 6);
      checkOutput("bp_len", readLog.size(), 3);
      if (readLog.size() == 3) begin
         checkOutput("bp0", readLog[0], 16'h1111);
         checkOutput("bp2", readLog[2], 16'h3333);
      end

      $display("[TB] write gaps");
      wdata = '{16'h0B01, 16'h0B02, 16'h0B03};
      applyStimulus(1'b0, 200, 3, 32'b10101, 0, dc);
      checkOutput("gap_done_cycle", dc, 6);
      applyStimulus(1'b1, 200, 3, 32'hFFFF_FFFF, 0, dc);
      checkOutput("gap_len", readLog.size(), 3);
      if (readLog.size() == 3) begin
         checkOutput("gap0", readLog[0], 16'h0B01);
         checkOutput("gap1", readLog[1], 16'h0B02);
         checkOutput("gap2", readLog[2], 16'h0B03);
      end

      $display("[TB] zero count");
      applyStimulus(1'b0, 50, 0, 32'hFFFF_FFFF, 0, dc);
      checkOutput("zero_wr_done", dc, 1);
      applyStimulus(1'b1, 50, 0, 32'hFFFF_FFFF, 0, dc);
      checkOutput("zero_rd_done", dc, 1);
      checkOutput("zero_rd_len", readLog.size(), 0);

      $display("[TB] start while busy");
      wdata = '{16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
      applyStimulus(1'b0, 300, 4, 32'hFFFF_FFFF, 2, dc);
      checkOutput("busy_start_done", dc, 5);
      applyStimulus(1'b1, 300, 4, 32'hFFFF_FFFF, 0, dc);
      if (readLog.size() == 4) begin
         checkOutput("bs0", readLog[0], 16'h00C1);
         checkOutput("bs3", readLog[3], 16'h00C4);
      end else begin
         checkOutput("bs_len", readLog.size(), 4);
      end

      $display("[TB] reset mid-burst");
      doneBefore = doneCount;
      @(posedge clk); #1;
      start = 1'b1; mode = 1'b0; base = 9'd100; count = 10'd4;
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b1; s_data = 16'h5A01;
      @(posedge clk); #1;
      s_data = 16'h5A02;
      @(posedge clk); #1;
      reset = 1'b1; s_data = 16'h5A03;
      @(negedge clk);
      checkOutput("rst_mid_load", ram_load, 0);
      checkOutput("rst_mid_ready", s_ready, 0);
      checkOutput("rst_mid_busy", busy, 0);
      @(posedge clk); #1;
      reset = 1'b0; s_valid = 1'b0; s_data = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_no_done", doneCount, doneBefore);
      applyStimulus(1'b1, 100, 3, 32'hFFFF_FFFF, 0, dc);
      checkOutput("rst_rd_done", dc, 4);
      if (readLog.size() == 3) begin
         checkOutput("rst_rd0", readLog[0], 16'h5A01);
         checkOutput("rst_rd1", readLog[1], 16'h5A02);
         checkOutput("rst_rd2", readLog[2], 16'h0000);
      end else begin
         checkOutput("rst_rd_len", readLog.size(), 3);
      end

      $display("[TB] full 512 fill");
      wdata.delete();
      for (int i = 0; i < 512; i++) wdata.push_back(16'hFFFF);
      applyStimulus(1'b0, 0, 512, 32'hFFFF_FFFF, 0, dc);
      checkOutput("full_wr_done", dc, 513);
      applyStimulus(1'b1, 37, 512, 32'hFFFF_FFFF, 0, dc);
      checkOutput("full_rd_done", dc, 513);
      ffCount = 0;
      foreach (readLog[i]) if (readLog[i] == 16'hFFFF) ffCount++;
      checkOutput("full_ff_count", ffCount, 512);

      repeat (3) @(posedge clk);
      checking = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
